// File: rtl/dac_serial_rx_if.sv
// Parallel stereo pair stream out of the DAC deserialiser.
// The master presents pairs; the slave accepts with out_ready.
interface dac_serial_rx_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] out_left;
    logic [WIDTH-1:0] out_right;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_left,
        output out_right,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_left,
        input  out_right,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/dac_serial_rx.sv
// 3-wire audio DAC stream deserialiser: oversamples bitck/lrck/data,
// frames left/right words and presents stereo pairs with valid/ready.
module dac_serial_rx #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_bitck,
    input  logic          s_lrck,
    input  logic          s_dat,
    dac_serial_rx_if.master pair,
    output logic          locked,
    output logic          overrun,
    output logic          short_word
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [7:0]    TO   = 8'(TIMEOUT);

    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

    state_t state, state_n;

    logic bck_s1, bck_s2, bck_s3;
    logic lr_s1, lr_s2;
    logic dat_s1, dat_s2;
    logic ev, ev_lr, ev_dat;

    logic             prev_lr, prev_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic [WIDTH-1:0] left_q, left_n;
    logic [WIDTH-1:0] right_q, right_n;
    logic             valid_q, valid_n;
    logic             locked_n, overrun_n, short_n;
    logic [7:0]       tcnt, tcnt_n;

    logic rise, fall, pair_done;

    assign pair.out_left  = left_q;
    assign pair.out_right = right_q;
    assign pair.out_valid = valid_q;

    // Synchronise the serial lines and register the bit event with its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bck_s1 <= 1'b0;
            bck_s2 <= 1'b0;
            bck_s3 <= 1'b0;
            lr_s1  <= 1'b0;
            lr_s2  <= 1'b0;
            dat_s1 <= 1'b0;
            dat_s2 <= 1'b0;
            ev     <= 1'b0;
            ev_lr  <= 1'b0;
            ev_dat <= 1'b0;
        end else begin
            bck_s1 <= s_bitck;
            bck_s2 <= bck_s1;
            bck_s3 <= bck_s2;
            lr_s1  <= s_lrck;
            lr_s2  <= lr_s1;
            dat_s1 <= s_dat;
            dat_s2 <= dat_s1;
            ev     <= bck_s2 & ~bck_s3;
            ev_lr  <= lr_s2;
            ev_dat <= dat_s2;
        end
    end

    // Framing state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HUNT;
        else     state <= state_n;
    end

    // Word accumulator, output pair and status registers.
    // prev_lr resets high so a stream starting on a left word frames at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_lr    <= 1'b1;
            sh         <= '0;
            cnt        <= '0;
            hold       <= '0;
            left_q     <= '0;
            right_q    <= '0;
            valid_q    <= 1'b0;
            locked     <= 1'b0;
            overrun    <= 1'b0;
            short_word <= 1'b0;
            tcnt       <= '0;
        end else begin
            prev_lr    <= prev_n;
            sh         <= sh_n;
            cnt        <= cnt_n;
            hold       <= hold_n;
            left_q     <= left_n;
            right_q    <= right_n;
            valid_q    <= valid_n;
            locked     <= locked_n;
            overrun    <= overrun_n;
            short_word <= short_n;
            tcnt       <= tcnt_n;
        end
    end

    assign rise = ev && (ev_lr != prev_lr) && ev_lr;
    assign fall = ev && (ev_lr != prev_lr) && !ev_lr;

    // Next-state, word assembly, pair handoff and timeout.
    always_comb begin
        state_n   = state;
        prev_n    = prev_lr;
        sh_n      = sh;
        cnt_n     = cnt;
        hold_n    = hold;
        left_n    = left_q;
        right_n   = right_q;
        valid_n   = valid_q & ~pair.out_ready;
        locked_n  = locked;
        overrun_n = 1'b0;
        short_n   = 1'b0;
        pair_done = 1'b0;
        tcnt_n    = (tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;

        if (ev) begin
            prev_n = ev_lr;
            tcnt_n = '0;
        end

        if (!ev && tcnt >= TO) begin
            state_n  = HUNT;
            locked_n = 1'b0;
            sh_n     = '0;
            cnt_n    = '0;
        end else begin
            unique case (state)
                HUNT: begin
                    if (fall) begin
                        sh_n = '0;
                        sh_n[WIDTH-1] = ev_dat;
                        cnt_n   = ONE;
                        state_n = LEFT;
                    end
                end
                LEFT, RIGHT: begin
                    if ((state == LEFT && rise) ||
                        (state == RIGHT && fall)) begin
                        short_n = (cnt < FULL);
                        if (state == LEFT) begin
                            hold_n   = sh;
                            locked_n = 1'b1;
                            state_n  = RIGHT;
                        end else begin
                            pair_done = 1'b1;
                            state_n   = LEFT;
                        end
                        sh_n = '0;
                        sh_n[WIDTH-1] = ev_dat;
                        cnt_n = ONE;
                    end else if (ev && cnt < FULL) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            if (i == WIDTH - 1 - int'(cnt))
                                sh_n[i] = ev_dat;
                        end
                        cnt_n = cnt + ONE;
                    end
                end
                default: state_n = HUNT;
            endcase
        end

        if (pair_done) begin
            if (!valid_q || pair.out_ready) begin
                left_n  = hold;
                right_n = sh;
                valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end
    end
endmodule
